multicycle_control: RTL and testbench

Main control FSM of the multicycle MIPS datapath. Decodes the 6-bit opcode held in the instruction register and sequences fetch, decode, execute, memory and write-back steps. Produces every datapath enable and mux select, including the 4-bit `ALUOp` class code consumed by the ALU control decoder. Memory accesses use a ready handshake so that multi-cycle memories stall the FSM.

---
 rtl/multicycle_control_if.sv | 25 ++
 rtl/multicycle_control.sv | 166 ++++++++++++++++
 tb/tb_multicycle_control.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle main FSM and the MIPS datapath.
// master = control FSM side, slave = datapath/memory side.
interface multicycle_control_if;
  logic [5:0] Opcode;
  logic       MemReady;
  logic       PCWrite, BranchEQ, BranchNE;
  logic       IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] RegDst, MemToReg, ALUSrcB, PCSource;
  logic [3:0] ALUOp;
  logic       InstrDone, Illegal;

  modport master (
    input  Opcode, MemReady,
    output PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, ALUSrcA, RegDst, MemToReg, ALUSrcB, PCSource, ALUOp,
           InstrDone, Illegal
  );

  modport slave (
    output Opcode, MemReady,
    input  PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, ALUSrcA, RegDst, MemToReg, ALUSrcB, PCSource, ALUOp,
           InstrDone, Illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath (fetch/decode/exec/mem/wb).
// Define MULTICYCLE_JUMP_EN to build the J/JAL states; otherwise those opcodes trap.
module multicycle_control (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        bus
);
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
`endif

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB_R = 4'd5,
    S_ALU_WB_I = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
`ifdef MULTICYCLE_JUMP_EN
    S_JUMP     = 4'd12,
    S_JAL      = 4'd13,
`endif
    S_TRAP     = 4'd14
  } state_t;

  state_t r_state, w_next;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = S_INIT;
    bus.PCWrite   = 1'b0;
    bus.BranchEQ  = 1'b0;
    bus.BranchNE  = 1'b0;
    bus.IorD      = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.RegDst    = 2'b00;
    bus.MemToReg  = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.PCSource  = 2'b00;
    bus.ALUOp     = 4'b0000;
    bus.InstrDone = 1'b0;
    bus.Illegal   = 1'b0;
    case (r_state)
      S_INIT: w_next = S_FETCH;
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 4'b0001;
        bus.IRWrite = bus.MemReady;
        bus.PCWrite = bus.MemReady;
        w_next      = bus.MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute the branch target (PC+4 + imm<<2) into ALUOut.
        bus.ALUSrcB = 2'b11;
        bus.ALUOp   = 4'b0001;
        case (bus.Opcode)
          OP_R:                              w_next = S_EXEC_R;
          OP_ADDI, OP_ORI, OP_LUI, OP_ANDI:  w_next = S_EXEC_I;
          OP_LW, OP_SW:                      w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                    w_next = S_BRANCH;
`ifdef MULTICYCLE_JUMP_EN
          OP_J:                              w_next = S_JUMP;
          OP_JAL:                            w_next = S_JAL;
`endif
          default:                           w_next = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        bus.ALUSrcA = 1'b1;
        w_next      = S_ALU_WB_R;
      end
      S_EXEC_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        case (bus.Opcode)
          OP_ORI:  bus.ALUOp = 4'b0010;
          OP_LUI:  bus.ALUOp = 4'b0011;
          OP_ANDI: bus.ALUOp = 4'b0100;
          default: bus.ALUOp = 4'b0001;
        endcase
        w_next = S_ALU_WB_I;
      end
      S_ALU_WB_R, S_ALU_WB_I: begin
        bus.RegWrite  = 1'b1;
        bus.RegDst    = (r_state == S_ALU_WB_R) ? 2'b01 : 2'b00;
        bus.InstrDone = 1'b1;
        w_next        = S_FETCH;
      end
      S_MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.ALUOp   = (bus.Opcode == OP_LW) ? 4'b0111 : 4'b1000;
        w_next      = (bus.Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        w_next      = bus.MemReady ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        bus.RegWrite  = 1'b1;
        bus.MemToReg  = 2'b01;
        bus.InstrDone = 1'b1;
        w_next        = S_FETCH;
      end
      S_MEM_WR: begin
        bus.MemWrite  = 1'b1;
        bus.IorD      = 1'b1;
        bus.InstrDone = bus.MemReady;
        w_next        = bus.MemReady ? S_FETCH : S_MEM_WR;
      end
      S_BRANCH: begin
        bus.ALUSrcA   = 1'b1;
        bus.PCSource  = 2'b01;
        bus.BranchEQ  = (bus.Opcode == OP_BEQ);
        bus.BranchNE  = (bus.Opcode != OP_BEQ);
        bus.ALUOp     = (bus.Opcode == OP_BEQ) ? 4'b0101 : 4'b0110;
        bus.InstrDone = 1'b1;
        w_next        = S_FETCH;
      end
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP, S_JAL: begin
        bus.PCWrite   = 1'b1;
        bus.PCSource  = 2'b10;
        bus.InstrDone = 1'b1;
        if (r_state == S_JAL) begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = 2'b10;
          bus.MemToReg = 2'b10;
        end
        w_next = S_FETCH;
      end
`endif
      S_TRAP: begin
        bus.Illegal = 1'b1;
        w_next      = S_TRAP;
      end
      default: w_next = S_INIT;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction expected control
// words come from a table of instruction steps, with random memory wait states.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if bus();
  multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic pcw, beq, bne, iord, mrd, mwr, irw, rgw, srca;
    logic [1:0] rdst, m2r, srcb, pcsrc;
    logic [3:0] aluop;
    logic done, ill;
  } cw_t;

  typedef struct packed {
    cw_t  rdy;   // word while MemReady high (or for non-memory steps)
    cw_t  nrd;   // word while a memory step is still waiting
    logic wt;
  } step_t;

  step_t steps[$];
  int n_err = 0;
  int n_chk = 0;

  localparam logic [5:0] OPS [12] = '{6'b000000, 6'b001000, 6'b001101, 6'b001111,
                                      6'b001100, 6'b100011, 6'b101011, 6'b000100,
                                      6'b000101, 6'b000010, 6'b000011, 6'b000000};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic cw_t get_cw();
    cw_t c;
    c.pcw = bus.PCWrite;   c.beq = bus.BranchEQ;  c.bne = bus.BranchNE;
    c.iord = bus.IorD;     c.mrd = bus.MemRead;   c.mwr = bus.MemWrite;
    c.irw = bus.IRWrite;   c.rgw = bus.RegWrite;  c.srca = bus.ALUSrcA;
    c.rdst = bus.RegDst;   c.m2r = bus.MemToReg;  c.srcb = bus.ALUSrcB;
    c.pcsrc = bus.PCSource; c.aluop = bus.ALUOp;
    c.done = bus.InstrDone; c.ill = bus.Illegal;
    return c;
  endfunction

  function automatic void push(input cw_t w);
    step_t s;
    s.rdy = w; s.nrd = w; s.wt = 1'b0;
    steps.push_back(s);
  endfunction

  function automatic void push_w(input cw_t r, input cw_t n);
    step_t s;
    s.rdy = r; s.nrd = n; s.wt = 1'b1;
    steps.push_back(s);
  endfunction

  // Expected step list for one instruction; returns 1 if the opcode traps.
  function automatic bit build(input logic [5:0] op);
    cw_t c, r;
    bit trap;
    trap = 1'b0;
    steps.delete();
    c = '0; c.mrd = 1'b1; c.srcb = 2'b01; c.aluop = 4'd1;
    r = c;  r.irw = 1'b1; r.pcw = 1'b1;
    push_w(r, c);
    c = '0; c.srcb = 2'b11; c.aluop = 4'd1;
    push(c);
    c = '0;
    case (op)
      6'b000000: begin
        c.srca = 1'b1; push(c);
        c = '0; c.rgw = 1'b1; c.rdst = 2'b01; c.done = 1'b1; push(c);
      end
      6'b001000, 6'b001101, 6'b001111, 6'b001100: begin
        c.srca = 1'b1; c.srcb = 2'b10;
        c.aluop = (op == 6'b001101) ? 4'd2 : (op == 6'b001111) ? 4'd3 :
                  (op == 6'b001100) ? 4'd4 : 4'd1;
        push(c);
        c = '0; c.rgw = 1'b1; c.done = 1'b1; push(c);
      end
      6'b100011: begin
        c.srca = 1'b1; c.srcb = 2'b10; c.aluop = 4'd7; push(c);
        c = '0; c.mrd = 1'b1; c.iord = 1'b1; push_w(c, c);
        c = '0; c.rgw = 1'b1; c.m2r = 2'b01; c.done = 1'b1; push(c);
      end
      6'b101011: begin
        c.srca = 1'b1; c.srcb = 2'b10; c.aluop = 4'd8; push(c);
        c = '0; c.mwr = 1'b1; c.iord = 1'b1;
        r = c; r.done = 1'b1; push_w(r, c);
      end
      6'b000100, 6'b000101: begin
        c.srca = 1'b1; c.pcsrc = 2'b01; c.done = 1'b1;
        if (op[0]) begin c.bne = 1'b1; c.aluop = 4'd6; end
        else       begin c.beq = 1'b1; c.aluop = 4'd5; end
        push(c);
      end
`ifdef MULTICYCLE_JUMP_EN
      6'b000010, 6'b000011: begin
        c.pcw = 1'b1; c.pcsrc = 2'b10; c.done = 1'b1;
        if (op[0]) begin c.rgw = 1'b1; c.rdst = 2'b10; c.m2r = 2'b10; end
        push(c);
      end
`endif
      default: begin
        c.ill = 1'b1; push(c); trap = 1'b1;
      end
    endcase
    return trap;
  endfunction

  task automatic cyc(input logic [5:0] op, input logic mr, input cw_t exp, input string tag);
    bus.Opcode = op; bus.MemReady = mr;
    @(negedge clk);
    chk(tag, 32'(get_cw()), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.MemReady = 1'($urandom); bus.Opcode = 6'($urandom);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(6'($urandom), 1'($urandom), '0, "init");
  endtask

  // Opcode is garbage during fetch; the real one is held from decode onward.
  task automatic run(input logic [5:0] op, input int fw, input int mw, input string tag);
    bit trap;
    trap = build(op);
    foreach (steps[k]) begin
      logic [5:0] o;
      int w;
      o = (k == 0) ? 6'($urandom) : op;
      w = (k == 0) ? fw : mw;
      if (steps[k].wt) begin
        for (int i = 0; i < w; i++) cyc(o, 1'b0, steps[k].nrd, tag);
        cyc(o, 1'b1, steps[k].rdy, tag);
      end else begin
        cyc(o, 1'($urandom), steps[k].rdy, tag);
      end
    end
    if (trap) begin
      for (int i = 0; i < 11; i++) cyc(op, 1'($urandom), steps[steps.size()-1].rdy, {tag, "_trap"});
      do_reset();
    end
  endtask

  initial begin
    reset = 1'b1; bus.Opcode = '0; bus.MemReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(6'd0, 1'b1, '0, "reset_init");

    run(6'b000000, 0, 0, "rtype");
    run(6'b100011, 0, 2, "lw_wait2");
    run(6'b001101, 1, 0, "ori");
    run(6'b000101, 0, 0, "bne");
    run(6'b000100, 2, 0, "beq");
    run(6'b000011, 0, 0, "jal");
    run(6'b101011, 0, 1, "sw");

    // Reset while a store is still waiting on memory: no retire, back to INIT.
    begin
      bit t;
      t = build(6'b101011);
      cyc(6'($urandom), 1'b1, steps[0].rdy, "swr_fetch");
      cyc(6'b101011, 1'($urandom), steps[1].rdy, "swr_dec");
      cyc(6'b101011, 1'($urandom), steps[2].rdy, "swr_addr");
      cyc(6'b101011, 1'b0, steps[3].nrd, "swr_wait");
      reset = 1'b1;
      cyc(6'b101011, 1'b0, steps[3].nrd, "swr_rst_cyc");
      reset = 1'b0;
      cyc(6'($urandom), 1'($urandom), '0, "swr_init");
      if (t) chk("swr_build", 32'(t), 32'd0);
    end
    run(6'b001111, 0, 0, "lui_after_rst");

    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else                           op = OPS[$urandom_range(0, 11)];
      run(op, $urandom_range(0, 2), $urandom_range(0, 2), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
